bpsk_symbol_demod: RTL and testbench

//   Downstream of the Costas carrier-recovery loop. Mixes the received BPSK samples with the

---
 rtl/bpsk_symbol_demod.sv | 92 +++++++++
 tb/tb_bpsk_symbol_demod.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bpsk_symbol_demod.sv
// bpsk_symbol_demod: mixes BPSK samples with the recovered carrier, integrates-and-dumps per symbol and queues sliced bits
module bpsk_symbol_demod #(
  parameter int SPS = 16,
  parameter int ACC_W = 32,
  parameter int SETTLE = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bpsk_in,
  input  logic [7:0]  cos_ref,
  input  logic        locked,
  input  logic        bit_ready,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        running,
  output logic        overflow,
  output logic [15:0] sym_count
);
  localparam int CW = $clog2(SPS);
  localparam int SCW = $clog2(SETTLE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (ACC_W > 25 ? ACC_W : 25) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = -MAXV;
  typedef enum logic [1:0] {IDLE, ACQ, RUN} state_t;
  state_t state_q, state_d;
  logic signed [24:0] prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic signed [SW-1:0] sum_w;
  logic signed [8:0] ref_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SCW-1:0] settle_q, settle_d;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic ovf_q, ovf_d;
  logic [15:0] sym_q, sym_d;
  logic full, empty, pop, push, dump, integ;
  always_comb begin
    ref_s = $signed({1'b0, cos_ref}) - 9'sd128;
    prod_d = 25'($signed(bpsk_in)) * 25'(ref_s);
    sum_w = SW'(acc_q) + SW'(prod_q);
    sum = sum_w > MAXV ? ACC_W'(MAXV) : sum_w < MINV ? ACC_W'(MINV) : ACC_W'(sum_w);
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop = !empty && bit_ready;
    dump = state_q == RUN && locked && cnt_q == CW'(SPS - 1);
    integ = state_q == RUN && locked && !dump;
    push = dump && (!full || pop);
    state_d = state_q == IDLE ? (locked ? ACQ : IDLE)
            : !locked ? IDLE
            : (state_q == ACQ && settle_q == SCW'(SETTLE - 1)) ? RUN : state_q;
    settle_d = (state_q == ACQ && locked) ? settle_q + SCW'(1) : '0;
    acc_d = integ ? sum : '0;
    cnt_d = integ ? cnt_q + CW'(1) : '0;
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = !sum[ACC_W-1];
    wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    ovf_d = ovf_q | (dump && full && !pop);
    sym_d = push ? sym_q + 16'd1 : sym_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      prod_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      settle_q <= '0;
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      sym_q <= '0;
    end else begin
      state_q <= state_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      settle_q <= settle_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      sym_q <= sym_d;
    end
  assign bit_out = mem_q[rd_q[AW-1:0]];
  assign bit_valid = !empty;
  assign running = state_q == RUN;
  assign overflow = ovf_q;
  assign sym_count = sym_q;
endmodule

// File: tb/tb_bpsk_symbol_demod.sv
// tb_bpsk_symbol_demod: randomized scoreboard bench for bpsk_symbol_demod against a symbol-level reference model
module tb_bpsk_symbol_demod;
  localparam int SPS = 16, SETTLE = 64, DEPTH = 8;
  logic clk = 0, rst = 1;
  logic [15:0] bpsk_in = 0;
  logic [7:0] cos_ref = 128;
  logic locked = 0, bit_ready = 0;
  logic use_sat = 0, rand_rdy = 0, fixed_rdy = 0;
  logic bit_out, bit_valid, running, overflow;
  logic bit_out2, bit_valid2, running2, overflow2;
  logic [15:0] sym_count, sym_count2;
  logic running_sel, valid_sel;
  logic [15:0] cnt_sel;
  int checks = 0, errors = 0;
  int exp_cnt = 0, exp_cnt2 = 0;
  bit exp_q[$], exp_q2[$];
  bpsk_symbol_demod #(.SPS(SPS), .ACC_W(32), .SETTLE(SETTLE), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .bpsk_in(bpsk_in), .cos_ref(cos_ref), .locked(locked & ~use_sat),
    .bit_ready(bit_ready), .bit_out(bit_out), .bit_valid(bit_valid), .running(running),
    .overflow(overflow), .sym_count(sym_count));
  bpsk_symbol_demod #(.SPS(SPS), .ACC_W(16), .SETTLE(SETTLE), .FIFO_DEPTH(DEPTH)) u_sat (
    .clk(clk), .rst(rst), .bpsk_in(bpsk_in), .cos_ref(cos_ref), .locked(locked & use_sat),
    .bit_ready(bit_ready), .bit_out(bit_out2), .bit_valid(bit_valid2), .running(running2),
    .overflow(overflow2), .sym_count(sym_count2));
  assign running_sel = use_sat ? running2 : running;
  assign valid_sel = use_sat ? bit_valid2 : bit_valid;
  assign cnt_sel = use_sat ? sym_count2 : sym_count;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    bit_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end
  always @(negedge clk)
    if (!rst && bit_valid && bit_ready) begin
      if (exp_q.size() == 0) chk("bit_extra", bit_valid, 0);
      else chk("bit_out", bit_out, exp_q.pop_front());
    end
  always @(negedge clk)
    if (!rst && bit_valid2 && bit_ready) begin
      if (exp_q2.size() == 0) chk("bit_extra_sat", bit_valid2, 0);
      else chk("bit_out_sat", bit_out2, exp_q2.pop_front());
    end
  function automatic longint sat(input longint v, input int w);
    longint m = (longint'(1) <<< (w - 1)) - 1;
    return v > m ? m : v < -m ? -m : v;
  endfunction
  task automatic step(input int s, input int c, input logic l);
    bpsk_in = 16'(s);
    cos_ref = 8'(c);
    locked = l;
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input bit b);
    if (use_sat) begin
      exp_q2.push_back(b);
      exp_cnt2++;
    end else begin
      exp_q.push_back(b);
      exp_cnt++;
    end
  endtask
  task automatic rnd_sample(input int pol, input int zero, output int s, output int c);
    s = pol != 0 ? int'($urandom_range(0, 4000)) - 1000 : 1000 - int'($urandom_range(0, 4000));
    c = zero != 0 ? 128 : int'($urandom_range(100, 255));
  endtask
  task automatic session(input int nsym, input int mode, input int extra, input int cap);
    longint acc = 0;
    int s, c, k, j, pol = 0, zero = 0, nacc = 0;
    for (int i = 0; i < SETTLE; i++) step(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)), 1);
    chk("running_acq", running_sel, 0);
    for (int i = 0; i <= nsym * SPS; i++) begin
      k = i / SPS;
      j = i % SPS;
      if (j == 0) begin
        pol = int'($urandom_range(0, 1));
        zero = int'($urandom_range(0, 5) == 0);
      end
      rnd_sample(pol, zero, s, c);
      if (mode == 1) begin
        s = 1000;
        c = 228;
      end else if (mode == 2) begin
        s = k % 2 != 0 ? -1000 : 1000;
        c = 228;
      end else if (mode == 3 && k % 4 != 3) begin
        s = (k % 4 == 1) ? -32768 : (k % 4 == 2 && j == SPS - 1) ? -1000 : 32767;
        c = (k % 4 == 2 && j == SPS - 1) ? 228 : 255;
      end
      if (k < nsym) acc = sat(acc + longint'(s) * longint'(c - 128), use_sat ? 16 : 32);
      step(s, c, 1);
      if (i == 0) chk("running_run", running_sel, 1);
      if (mode == 1 && i == SPS - 1) chk("latency_early", valid_sel, 0);
      if (mode == 1 && i == SPS) chk("latency_valid", valid_sel, 1);
      if (j == 0 && i > 0) chk("sym_count", cnt_sel, use_sat ? exp_cnt2 : exp_cnt);
      if (k < nsym && j == SPS - 1) begin
        if (nacc < cap) begin
          nacc++;
          push_exp(acc >= 0);
        end
        acc = 0;
      end
    end
    for (int i = 0; i < extra; i++) step(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)), 1);
    if (extra > 0) chk("running_pre_drop", running_sel, 1);
    step(0, 128, 0);
    chk("running_drop", running_sel, 0);
    step(0, 128, 0);
    chk("sym_count_drop", cnt_sel, use_sat ? exp_cnt2 : exp_cnt);
  endtask
  task automatic drain();
    int t = 0;
    rand_rdy = 0;
    fixed_rdy = 1;
    while ((exp_q.size() > 0 || exp_q2.size() > 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", exp_q.size() + exp_q2.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("valid_after_drain", bit_valid | bit_valid2, 0);
  endtask
  initial begin
    repeat (3) step(0, 128, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_sat_valid", bit_valid2, 0);
    rst = 0;
    session(1, 1, 0, 99);
    chk("lock_bit_out", bit_out, 1);
    chk("lock_bit_valid", bit_valid, 1);
    chk("lock_sym_count", sym_count, 1);
    drain();
    session(6, 2, 0, 99);
    rand_rdy = 1;
    repeat (3) session(3 + int'($urandom_range(0, 3)), 0, 0, 99);
    session(2, 0, 10, 99);
    session(3, 0, 0, 99);
    drain();
    chk("no_overflow", overflow, 0);
    fixed_rdy = 0;
    session(9, 0, 0, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_sym_count", sym_count, exp_cnt);
    chk("ovf_valid", bit_valid, 1);
    drain();
    chk("ovf_sticky", overflow, 1);
    use_sat = 1;
    rand_rdy = 1;
    session(8, 3, 0, 99);
    drain();
    chk("sat_no_overflow", overflow2, 0);
    use_sat = 0;
    fixed_rdy = 0;
    session(3, 0, 0, 99);
    chk("pre_rst_valid", bit_valid, 1);
    rst = 1;
    exp_q.delete();
    exp_cnt = 0;
    step(0, 128, 0);
    chk("mid_rst_sym_count", sym_count, 0);
    chk("mid_rst_valid", bit_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_bit_out", bit_out, 0);
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
